// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: default widths, opcode values
// and the sequencer state enumeration.
package alu_sequencer_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int OP_W_DEF  = 4;

   // Opcodes 0..7 are single-cycle ALU operations, 8 is the sequenced
   // multiply, everything above 8 is illegal.
   localparam int OP_ADD = 0;
   localparam int OP_SUB = 1;
   localparam int OP_AND = 2;
   localparam int OP_OR  = 3;
   localparam int OP_XOR = 4;
   localparam int OP_NOT = 5;
   localparam int OP_SHL = 6;
   localparam int OP_SHR = 7;
   localparam int OP_MUL = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus between the sequencer and the external combinational ALU.
// The sequencer drives registered operands/opcode and reads the result
// back in the same cycle.
interface alu_sequencer_if
   import alu_sequencer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OP_W  = OP_W_DEF
);

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OP_W-1:0]  alu_op;
   logic [WIDTH-1:0] alu_y;

   modport master (
      output alu_a,
      output alu_b,
      output alu_op,
      input  alu_y
   );

   modport slave (
      input  alu_a,
      input  alu_b,
      input  alu_op,
      output alu_y
   );

endinterface

// File: rtl/alu_sequencer_enable_sync.sv
// Synchronizer and rising-edge detector for the asynchronous enable input.
// Produces a one-cycle start pulse per genuine low-to-high transition.
module enable_sync
   import alu_sequencer_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   output logic start
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic sync3_q, sync3_d;
   logic fill1_q, fill1_d;
   logic fill2_q, fill2_d;
   logic armed_q, armed_d;

   // Next-state for the synchronizer chain; the fill chain marks when sync2
   // holds a real sample of enable rather than its reset value, and the
   // detector is only armed once enable has genuinely been seen low. This
   // keeps an enable that is already high at reset release from starting.
   always_comb begin
      sync1_d = enable;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      fill1_d = 1'b1;
      fill2_d = fill1_q;
      armed_d = armed_q | (fill2_q & ~sync2_q);
   end

   // Synchronizer, edge-detect and arming flops.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         fill1_q <= 1'b0;
         fill2_q <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         sync3_q <= sync3_d;
         fill1_q <= fill1_d;
         fill2_q <= fill2_d;
         armed_q <= armed_d;
      end
   end

   assign start = sync2_q & ~sync3_q & armed_q;

endmodule

// File: rtl/alu_sequencer.sv
// Sequences an external combinational ALU: single-cycle ops take one EXEC
// cycle, MUL is built from WIDTH shift-and-add steps through the ALU's ADD.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OP_W  = OP_W_DEF
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               enable,
   input  logic [OP_W-1:0]    operation,
   input  logic [2*WIDTH-1:0] sw,
   alu_sequencer_if.master    alu_bus,
   output logic [WIDTH-1:0]   rezult,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic             start;
   logic             op_single;
   logic             op_mul;
   logic [WIDTH-1:0] sw_a;
   logic [WIDTH-1:0] sw_b;
   logic             mul_last;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [OP_W-1:0]  alu_op_q, alu_op_d;
   logic [WIDTH-1:0] rezult_q, rezult_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] mul_a_q, mul_a_d;
   logic [WIDTH-1:0] mul_b_q, mul_b_d;

   // Partial product for bit i of the multiplier: A shifted by i, or zero.
   function automatic logic [WIDTH-1:0] partial(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [IDX_W-1:0] i);
      return b[i] ? (a << i) : '0;
   endfunction

   enable_sync u_enable_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (enable),
      .start   (start)
   );

   assign sw_a      = sw[WIDTH-1:0];
   assign sw_b      = sw[2*WIDTH-1:WIDTH];
   assign op_single = (operation <= OP_W'(OP_SHR));
   assign op_mul    = (operation == OP_W'(OP_MUL));
   assign mul_last  = (idx_q == IDX_W'(WIDTH - 1));

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a start seen outside IDLE is simply ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op_single)   state_d = S_EXEC;
               else if (op_mul) state_d = S_MUL;
               else             state_d = S_DONE;
            end
         end
         S_EXEC:  state_d = S_DONE;
         S_MUL:   if (mul_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs decoded from the current state.
   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
   end

   // Datapath next values: operand capture, result capture and the
   // multiply accumulation. During MUL the ALU bus carries acc and the next
   // partial product so that the ALU's ADD produces the new accumulator.
   always_comb begin
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_op_d = alu_op_q;
      rezult_d = rezult_q;
      err_d    = err_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op_single) begin
                  alu_a_d  = sw_a;
                  alu_b_d  = sw_b;
                  alu_op_d = operation;
                  err_d    = 1'b0;
               end else if (op_mul) begin
                  mul_a_d  = sw_a;
                  mul_b_d  = sw_b;
                  alu_op_d = OP_W'(OP_ADD);
                  acc_d    = '0;
                  idx_d    = '0;
                  alu_a_d  = '0;
                  alu_b_d  = partial(sw_a, sw_b, '0);
                  err_d    = 1'b0;
               end else begin
                  err_d    = 1'b1;
               end
            end
         end
         S_EXEC: begin
            rezult_d = alu_bus.alu_y;
         end
         S_MUL: begin
            acc_d   = alu_bus.alu_y;
            idx_d   = idx_q + 1'b1;
            alu_a_d = alu_bus.alu_y;
            alu_b_d = partial(mul_a_q, mul_b_q, idx_q + 1'b1);
            if (mul_last) begin
               rezult_d = alu_bus.alu_y;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         rezult_q <= '0;
         err_q    <= 1'b0;
         acc_q    <= '0;
         idx_q    <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
      end else begin
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         rezult_q <= rezult_d;
         err_q    <= err_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
      end
   end

   assign alu_bus.alu_a  = alu_a_q;
   assign alu_bus.alu_b  = alu_b_q;
   assign alu_bus.alu_op = alu_op_q;
   assign rezult         = rezult_q;
   assign err            = err_q;

endmodule
